// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: FSM states, control-output bundle and
// the all-zero control fields loaded into ID/EX when a bubble is inserted.
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  localparam logic [1:0] WB_ZERO = 2'b00;
  localparam logic [1:0] M_ZERO  = 2'b00;
  localparam logic [3:0] EX_ZERO = 4'b0000;

  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    logic [3:0] ex;
  } idex_ctrl_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_halt;
    logic idex_bubble;
    logic exmem_halt;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                           idex_halt: 1'b0, idex_bubble: 1'b1, exmem_halt: 1'b0};
  localparam hazard_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                           idex_halt: 1'b1, idex_bubble: 1'b0, exmem_halt: 1'b1};
  // A flush replaces IF/ID with a NOP, so the normal load enable stays off.
  localparam hazard_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1,
                                           idex_halt: 1'b0, idex_bubble: 1'b1, exmem_halt: 1'b0};
  localparam hazard_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                           idex_halt: 1'b0, idex_bubble: 1'b1, exmem_halt: 1'b0};
  localparam hazard_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                           idex_halt: 1'b0, idex_bubble: 1'b0, exmem_halt: 1'b0};

  function automatic idex_ctrl_t bubble_ctrl();
    idex_ctrl_t c;
    c.wb = WB_ZERO;
    c.m  = M_ZERO;
    c.ex = EX_ZERO;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in ID/EX and the
// source registers of the instruction in IF/ID. Register 0 never hazards.
module load_use_detect #(
  parameter int unsigned REG_W = pipe_pkg::REG_W
) (
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  output logic             loaduse_o
);

  logic w_rt_nonzero;
  logic w_src_match;

  always_comb begin
    w_rt_nonzero = (idex_rt_i != '0);
    w_src_match  = (idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i);
    loaduse_o    = idex_memread_i && w_rt_nonzero && w_src_match;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory
// handshake freeze with timeout into a sticky error, and a stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W       = pipe_pkg::REG_W,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_halt_o,
  output logic             idex_bubble_o,
  output logic             exmem_halt_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  import pipe_pkg::*;

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WaitW-1:0] r_wait_cnt;
  logic [WaitW-1:0] w_wait_nxt;
  logic [WaitW-1:0] w_wait_inc;
  logic             r_err;
  logic             w_err_set;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_freeze;
  logic             w_loaduse;
  logic             w_stall_evt;
  hazard_ctrl_t     w_ctrl;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .loaduse_o      (w_loaduse)
  );

  always_comb begin
    w_freeze = 1'b0;
    unique case (r_state)
      RUN:      w_freeze = mem_req_i && !mem_ack_i;
      MEM_WAIT: w_freeze = !mem_ack_i;
      HALTED:   w_freeze = 1'b1;
      default:  w_freeze = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_set   = 1'b0;
    w_wait_inc  = r_wait_cnt + 1'b1;
    unique case (r_state)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          w_wait_nxt = WaitW'(1);
          if (MEM_TIMEOUT <= 1) begin
            w_state_nxt = HALTED;
            w_err_set   = 1'b1;
          end else begin
            w_state_nxt = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else begin
          // The counter holds wait cycles already elapsed; this cycle adds one.
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc >= TimeoutVal) begin
            w_state_nxt = HALTED;
            w_err_set   = 1'b1;
          end
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_stall_evt = w_freeze || (w_loaduse && !branch_taken_i);
    if (!rst_i) begin
      w_ctrl = CTRL_RESET;
    end else if (w_freeze) begin
      w_ctrl = CTRL_FREEZE;
    end else if (branch_taken_i) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_loaduse) begin
      w_ctrl = CTRL_BUBBLE;
    end else begin
      w_ctrl = CTRL_NORMAL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pc_write_o    = w_ctrl.pc_write;
    ifid_write_o  = w_ctrl.ifid_write;
    ifid_flush_o  = w_ctrl.ifid_flush;
    idex_halt_o   = w_ctrl.idex_halt;
    idex_bubble_o = w_ctrl.idex_bubble;
    exmem_halt_o  = w_ctrl.exmem_halt;
    err_o         = r_err;
    stall_cnt_o   = r_stall_cnt;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver predicts each cycle from
// a behavioural model and queues it; a negedge monitor compares the DUT.
module tb_hazard_stall_ctrl;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 3;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [5:0]       ctrl;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_halt_o;
  logic             idex_bubble_o;
  logic             exmem_halt_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Behavioural model: memory-wait bookkeeping in plain integers.
  bit m_waiting = 0;
  bit m_halted  = 0;
  bit m_err     = 0;
  int m_waited  = 0;
  int m_stalls  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .REG_W       (REG_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_halt_o    (idex_halt_o),
    .idex_bubble_o  (idex_bubble_o),
    .exmem_halt_o   (exmem_halt_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic step(input bit rst, input bit mr, input int rt, input int rs, input int rt2,
                      input bit br, input bit req, input bit ack);
    bit   lu;
    bit   frz;
    exp_t e;
    @(posedge clk);
    #1;
    rst_i          = rst;
    idex_memread_i = mr;
    idex_rt_i      = REG_W'(rt);
    ifid_rs_i      = REG_W'(rs);
    ifid_rt_i      = REG_W'(rt2);
    branch_taken_i = br;
    mem_req_i      = req;
    mem_ack_i      = ack;

    lu  = mr && (rt != 0) && (rt == rs || rt == rt2);
    if (m_halted)       frz = 1;
    else if (m_waiting) frz = !ack;
    else                frz = req && !ack;

    // ctrl = {pc_write, ifid_write, ifid_flush, idex_halt, idex_bubble, exmem_halt}
    if (!rst)     e.ctrl = 6'b000010;
    else if (frz) e.ctrl = 6'b000101;
    else if (br)  e.ctrl = 6'b101010;
    else if (lu)  e.ctrl = 6'b000010;
    else          e.ctrl = 6'b110000;
    e.err = m_err;
    e.cnt = CNT_W'(m_stalls);
    q.push_back(e);

    if (!rst) begin
      m_waiting = 0; m_halted = 0; m_err = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if ((frz || (lu && !br)) && m_stalls < CNT_MAX) m_stalls++;
      if (m_waiting && !m_halted) begin
        if (ack) begin
          m_waiting = 0;
          m_waited  = 0;
        end else begin
          m_waited++;
          if (m_waited >= MEM_TIMEOUT) begin m_halted = 1; m_err = 1; end
        end
      end else if (!m_halted && req && !ack) begin
        m_waiting = 1;
        m_waited  = 1;
        if (m_waited >= MEM_TIMEOUT) begin m_halted = 1; m_err = 1; end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({pc_write_o, ifid_write_o, ifid_flush_o, idex_halt_o, idex_bubble_o, exmem_halt_o}
          !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time,
                 {pc_write_o, ifid_write_o, ifid_flush_o, idex_halt_o, idex_bubble_o,
                  exmem_halt_o}, e.ctrl);
      end
      n_cmp++;
      if (err_o !== e.err) begin
        n_fail++;
        $display("FAIL err t=%0t got=%b want=%b", $time, err_o, e.err);
      end
      n_cmp++;
      if (stall_cnt_o !== e.cnt) begin
        n_fail++;
        $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt_o, e.cnt);
      end
    end
  end

  initial begin
    rst_i = 0; idex_memread_i = 0; idex_rt_i = 0; ifid_rs_i = 0; ifid_rt_i = 0;
    branch_taken_i = 0; mem_req_i = 0; mem_ack_i = 0;
    @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8, 8, 0, 1, 1, 0);

    // Load-use bubble, then normal with stall count 1
    step(1, 1, 8, 8, 0, 0, 0, 0);
    idle(2);
    // $zero exclusion and no-match
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 8, 10, 0, 0, 0);
    // Branch overrides load-use and is not counted
    step(1, 1, 8, 8, 0, 1, 0, 0);
    idle(1);
    // Three-cycle memory wait, ack releases; then same-cycle req+ack
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // Timeout into sticky error, late ack ignored, reset recovers
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 8, 8, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Reset on the second wait cycle
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Saturation of the narrow stall counter
    for (int i = 0; i < 10; i++) step(1, 1, 3, 0, 3, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 1) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) != 0));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
